// File: rtl/full_adder.sv
// Registered single-bit full adder with one-cycle latency and an optional pair of
// saturating statistics counters, compiled in when FULL_ADDER_STATS_EN is defined.
module full_adder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    output logic             sum,
    output logic             cout,
    output logic             out_valid
`ifdef FULL_ADDER_STATS_EN
    ,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] carry_count
`endif
);

    // Reject counter widths outside 4..32 during elaboration.
    if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
        $error("full_adder: CNT_W must be in the range 4..32");
    end

    logic [1:0] w_result;
    logic       r_sum;
    logic       r_cout;
    logic       r_valid;

    assign w_result = {1'b0, a} + {1'b0, b} + {1'b0, cin};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= 1'b0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_result[0];
                r_cout <= w_result[1];
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_valid;

`ifdef FULL_ADDER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_op_count;
    logic [CNT_W-1:0] r_carry_count;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count    <= '0;
            r_carry_count <= '0;
        end else if (in_valid) begin
            if (r_op_count != CNT_MAX) begin
                r_op_count <= r_op_count + 1'b1;
            end
            if (w_result[1] && (r_carry_count != CNT_MAX)) begin
                r_carry_count <= r_carry_count + 1'b1;
            end
        end
    end

    assign op_count    = r_op_count;
    assign carry_count = r_carry_count;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: directed scenarios plus randomized traffic
// against an arithmetic reference model; counter checks need FULL_ADDER_STATS_EN.
module tb_full_adder;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAXV = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic a;
    logic b;
    logic cin;
    logic sum;
    logic cout;
    logic out_valid;
`ifdef FULL_ADDER_STATS_EN
    logic [TB_CNT_W-1:0] op_count;
    logic [TB_CNT_W-1:0] carry_count;
    int mOp;
    int mCarry;
`endif

    int checks = 0;
    int errors = 0;
    int mSum;
    int mCout;
    int mValid;

    full_adder #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .a(a),
        .b(b),
        .cin(cin),
        .sum(sum),
        .cout(cout),
        .out_valid(out_valid)
`ifdef FULL_ADDER_STATS_EN
        ,
        .op_count(op_count),
        .carry_count(carry_count)
`endif
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus, advance the reference model, settle past the edge.
    task automatic drive(input logic r, input logic v, input logic ia, input logic ib, input logic ic);
        int total;
        rst = r;
        in_valid = v;
        a = ia;
        b = ib;
        cin = ic;
        @(posedge clk);
        if (r) begin
            mSum = 0;
            mCout = 0;
            mValid = 0;
`ifdef FULL_ADDER_STATS_EN
            mOp = 0;
            mCarry = 0;
`endif
        end else if (v) begin
            total = int'(ia) + int'(ib) + int'(ic);
            mSum = total % 2;
            mCout = total / 2;
            mValid = 1;
`ifdef FULL_ADDER_STATS_EN
            if (mOp < CNT_MAXV) mOp = mOp + 1;
            if (mCout == 1 && mCarry < CNT_MAXV) mCarry = mCarry + 1;
`endif
        end else begin
            mValid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({cout, sum, out_valid} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got cout,sum,valid=%b%b%b expected 000", cout, sum, out_valid);
        end
`ifdef FULL_ADDER_STATS_EN
        checks++;
        if (op_count !== '0 || carry_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got op=%0d carry=%0d expected 0 0", op_count, carry_count);
        end
`endif
    endtask

    task automatic test_truth_table();
        int expTT[8] = '{0, 1, 1, 2, 1, 2, 2, 3};
        logic [2:0] pattern;
        for (int i = 0; i < 8; i++) begin
            pattern = 3'(i);
            drive(1'b0, 1'b1, pattern[2], pattern[1], pattern[0]);
            checks++;
            if ({cout, sum} !== 2'(expTT[i]) || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL truth_%0d: got cout,sum=%b%b valid=%b expected %02b valid=1",
                         i, cout, sum, out_valid, 2'(expTT[i]));
            end
        end
`ifdef FULL_ADDER_STATS_EN
        checks++;
        if (op_count !== 4'd8 || carry_count !== 4'd4) begin
            errors++;
            $display("[TB] FAIL truth_counters: got op=%0d carry=%0d expected 8 4", op_count, carry_count);
        end
`endif
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({cout, sum} !== 2'b11 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_load: got cout,sum=%b%b valid=%b expected 11 valid=1", cout, sum, out_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({cout, sum} !== 2'b11 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_zero: got cout,sum=%b%b valid=%b expected 11 valid=0", cout, sum, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'bx, 1'bx, 1'bx);
            checks++;
            if ({cout, sum} !== 2'b11 || out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_x_%0d: got cout,sum=%b%b valid=%b expected 11 valid=0",
                         i, cout, sum, out_valid);
            end
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({cout, sum, out_valid} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL rst_priority: got cout,sum,valid=%b%b%b expected 000", cout, sum, out_valid);
        end
`ifdef FULL_ADDER_STATS_EN
        checks++;
        if (op_count !== '0 || carry_count !== '0) begin
            errors++;
            $display("[TB] FAIL rst_priority_cnt: got op=%0d carry=%0d expected 0 0", op_count, carry_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({cout, sum} !== 2'b10 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_first: got cout,sum=%b%b valid=%b expected 10 valid=1", cout, sum, out_valid);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({cout, sum} !== 2'b01 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_second: got cout,sum=%b%b valid=%b expected 01 valid=1", cout, sum, out_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic r;
        logic v;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 19) == 0);
            v = $urandom_range(0, 3) != 0;
            drive(r, v, 1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (sum !== 1'(mSum) || cout !== 1'(mCout) || out_valid !== 1'(mValid)) begin
                errors++;
                $display("[TB] FAIL random_%0d: got cout,sum,valid=%b%b%b expected %0d%0d%0d",
                         i, cout, sum, out_valid, mCout, mSum, mValid);
            end
`ifdef FULL_ADDER_STATS_EN
            checks++;
            if (op_count !== TB_CNT_W'(mOp) || carry_count !== TB_CNT_W'(mCarry)) begin
                errors++;
                $display("[TB] FAIL random_cnt_%0d: got op=%0d carry=%0d expected %0d %0d",
                         i, op_count, carry_count, mOp, mCarry);
            end
`endif
        end
    endtask

`ifdef FULL_ADDER_STATS_EN
    task automatic test_saturation();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        checks++;
        if (op_count !== 4'd15 || carry_count !== 4'd15) begin
            errors++;
            $display("[TB] FAIL saturation: got op=%0d carry=%0d expected 15 15", op_count, carry_count);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (op_count !== 4'd15 || carry_count !== 4'd15 || {cout, sum} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL saturation_hold: got op=%0d carry=%0d cout,sum=%b%b expected 15 15 11",
                     op_count, carry_count, cout, sum);
        end
    endtask
`endif

    initial begin
        mSum = 0;
        mCout = 0;
        mValid = 0;
`ifdef FULL_ADDER_STATS_EN
        mOp = 0;
        mCarry = 0;
`endif
        test_reset();
        test_truth_table();
        test_hold();
        test_reset_priority();
        test_back_to_back();
        test_random();
`ifdef FULL_ADDER_STATS_EN
        test_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_adder.md
# full_adder

Registered single-bit full adder. Adds operands `a`, `b` and carry-in `cin` and presents `sum` and `cout` one clock after the inputs are qualified by `in_valid`. It is the leaf cell of the N-bit multiplier's partial-product adder array. An optional statistics block counts accepted operations and carry-outs for bring-up and debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of the statistics counters; legal range 4–32.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: qualifies `a`, `b` and `cin` in the current cycle.
- `a` input 1: operand A.
- `b` input 1: operand B.
- `cin` input 1: carry-in.
- `sum` output 1: registered sum bit, `a ^ b ^ cin`.
- `cout` output 1: registered carry-out, `(a & b) | (a & cin) | (b & cin)`.
- `out_valid` output 1: high for exactly the cycle after each accepted input.
- `op_count` output CNT_W: number of accepted operations. Present only with `FULL_ADDER_STATS_EN`.
- `carry_count` output CNT_W: number of accepted operations that produced `cout = 1`. Present only with `FULL_ADDER_STATS_EN`.

## Operation
- Combinational core: a 2-bit result `{cout, sum} = a + b + cin`, evaluated as integer addition of three 1-bit values. The result range is 0–3.
- Accept rule: on a rising edge with `rst = 0` and `in_valid = 1`, the core result is loaded into `sum` and `cout`, and `out_valid` is set to 1.
- With `in_valid = 0`:
  - `sum` and `cout` hold their previous values.
  - `out_valid` is 0.
  - Input values are ignored, including X and Z.
- No handshake back-pressure. Every valid input is accepted, and the block can accept one input per cycle.
- Statistics, when compiled in:
  - `op_count` increments by 1 for each accepted input.
  - `carry_count` increments by 1 for each accepted input whose computed `cout` is 1.
  - Both counters saturate at 2^CNT_W − 1 and do not wrap.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on `sum`, `cout` and `out_valid` after edge N.
- Throughput: one operation per cycle. Back-to-back valid inputs produce back-to-back `out_valid` pulses with the matching results.
- Reset values:
  - `sum = 0`, `cout = 0`, `out_valid = 0`.
  - `op_count = 0` and `carry_count = 0`, when present.
- Reset has priority. If `rst = 1` and `in_valid = 1` on the same edge, the input is discarded and all outputs take their reset values.
- Reset asserted mid-stream: the result already registered is cleared at that edge. No `out_valid` pulse is produced for an input accepted on the reset edge.
- The counter increment and the `sum`/`cout` update happen on the same edge. Counter values are therefore visible together with `out_valid`.
- No combinational path from any input to any output.

## Configuration
- `FULL_ADDER_STATS_EN` defined:
  - Ports `op_count` and `carry_count` exist.
  - The counters operate as described under Operation.
- `FULL_ADDER_STATS_EN` undefined:
  - Those ports and their counter logic are absent.
  - `sum`, `cout` and `out_valid` behave identically in both builds.

## Test plan
- Exhaustive truth table: present the 8 input combinations (a,b,cin) 000 → 111 in order, one per cycle, with `in_valid = 1`. Required `{cout,sum}` one cycle later, in order: 00, 01, 01, 10, 01, 10, 10, 11.
- Hold check: accept (1,1,1), giving `{cout,sum} = 11`. Then drop `in_valid` and drive (0,0,0) and then X for 3 cycles. Required: `{cout,sum}` stays 11 and `out_valid` stays 0.
- Reset priority: with `{cout,sum} = 11` registered, assert `rst` with `in_valid = 1` and inputs (1,1,0). Required after the edge: `sum = 0`, `cout = 0`, `out_valid = 0`, counters 0.
- Back-to-back throughput: apply (0,1,1) then (1,0,0) on consecutive cycles. Required: `out_valid` high for 2 consecutive cycles, with `{cout,sum}` = 10 then 01.
- Statistics (`FULL_ADDER_STATS_EN`):
  - After the exhaustive sequence, required `op_count = 8` and `carry_count = 4`.
  - With `CNT_W = 4`, apply 20 accepted (1,1,0) inputs. Required: both counters saturate at 15.
